// File: rtl/brew_sequencer_pkg.sv
// Shared types and drink tables for the brew sequencer.
package brew_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCheck    = 3'd1,
    StReject   = 3'd2,
    StDispense = 3'd3,
    StDone     = 3'd4
  } state_t;

  // Dispense order; the step counter walks this sequence.
  typedef enum logic [2:0] {
    IngWater     = 3'd0,
    IngCoffee    = 3'd1,
    IngSugar     = 3'd2,
    IngMilk      = 3'd3,
    IngChocolate = 3'd4
  } ingredient_t;

  localparam int unsigned NumSteps = 5;
  localparam int unsigned NumTypes = 5;

  // Price per drink type, in units of 100.
  localparam int unsigned PriceTable [NumTypes] = '{1, 2, 3, 4, 3};

  // Seconds per ingredient: water, coffee, sugar, milk, chocolate.
  localparam logic [2:0] RecipeTable [NumTypes][NumSteps] = '{
    '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0},  // americano
    '{3'd2, 3'd1, 3'd1, 3'd0, 3'd0},  // sweet
    '{3'd1, 3'd1, 3'd0, 3'd2, 3'd0},  // latte
    '{3'd1, 3'd1, 3'd0, 3'd1, 3'd2},  // mocha
    '{3'd1, 3'd0, 3'd0, 3'd1, 3'd2}   // chocolate
  };

  function automatic logic type_valid(logic [2:0] t);
    return t < 3'(NumTypes);
  endfunction

endpackage

// File: rtl/brew_sequencer_if.sv
// Order inputs and valve/status outputs of the brew sequencer.
interface brew_sequencer_if #(
  parameter int unsigned CREDIT_W = 4
) ();

  logic [CREDIT_W-1:0] credit;
  logic [2:0]          coffee_type;
  logic                confirm;
  logic                credit_clear;
  logic [CREDIT_W-1:0] change;
  logic                reject;
  logic                busy;
  logic                water;
  logic                coffee;
  logic                sugar;
  logic                milk;
  logic                chocolate;
  logic                finished;
  logic [2:0]          state;

  // Environment side: coin counters, switches, valves, display.
  modport master (
    output credit, coffee_type, confirm,
    input  credit_clear, change, reject, busy, water, coffee, sugar, milk, chocolate,
           finished, state
  );

  // Sequencer side.
  modport slave (
    input  credit, coffee_type, confirm,
    output credit_clear, change, reject, busy, water, coffee, sugar, milk, chocolate,
           finished, state
  );

endinterface

// File: rtl/brew_sequencer_tick_prescaler.sv
// One-cycle tick every TICK_DIV cycles, counted from the last clear.
module brew_sequencer_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  // Next count: restart on clear or after the last cycle of a period.
  always_comb begin
    wrap  = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d = (clear || wrap) ? '0 : cnt_q + CntW'(1);
    tick  = wrap;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/brew_sequencer.sv
// Drink order sequencer: credit check, change, timed valve sequence, done hold.
module brew_sequencer
  import brew_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned CREDIT_W  = 4,
  parameter int unsigned DONE_HOLD = 2
) (
  input logic             clock,
  input logic             reset,
  brew_sequencer_if.slave bus
);

  localparam int unsigned SecW = 8;

  state_t              state_q, state_d;
  logic                confirm_q;
  logic [2:0]          type_q, type_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [2:0]          step_q, step_d;
  logic [SecW-1:0]     sec_q, sec_d;

  logic                tick, presc_clear;
  logic                conf_edge, accept, phase_last, valve_on;
  logic [2:0]          type_idx, cur_dur;
  logic [CREDIT_W-1:0] price;
  logic [SecW-1:0]     limit;

  brew_sequencer_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .clear(presc_clear),
    .tick (tick)
  );

  // Decode latched order: price, current step duration, end of current second-count.
  always_comb begin
    conf_edge  = bus.confirm & ~confirm_q;
    type_idx   = type_valid(type_q) ? type_q : 3'd0;
    price      = CREDIT_W'(PriceTable[type_idx]);
    accept     = type_valid(type_q) && (credit_q >= price);
    cur_dur    = RecipeTable[type_idx][step_q];
    limit      = (state_q == StDone) ? SecW'(DONE_HOLD) : SecW'(cur_dur);
    phase_last = tick && (sec_q == limit - SecW'(1));
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      confirm_q <= 1'b0;
      type_q    <= '0;
      credit_q  <= '0;
      change_q  <= '0;
      step_q    <= '0;
      sec_q     <= '0;
    end else begin
      state_q   <= state_d;
      confirm_q <= bus.confirm;
      type_q    <= type_d;
      credit_q  <= credit_d;
      change_q  <= change_d;
      step_q    <= step_d;
      sec_q     <= sec_d;
    end
  end

  // Next-state and datapath updates; the prescaler is restarted on every phase entry.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    credit_d    = credit_q;
    change_d    = change_q;
    step_d      = step_q;
    sec_d       = sec_q;
    presc_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (conf_edge) begin
          state_d  = StCheck;
          type_d   = bus.coffee_type;
          credit_d = bus.credit;
        end
      end
      StCheck: begin
        presc_clear = 1'b1;
        sec_d       = '0;
        if (accept) begin
          state_d  = StDispense;
          step_d   = '0;
          change_d = credit_q - price;
        end else begin
          state_d = StReject;
        end
      end
      StReject: state_d = StIdle;
      StDispense: begin
        // A zero-length step still takes one cycle.
        if (cur_dur == 3'd0 || phase_last) begin
          presc_clear = 1'b1;
          sec_d       = '0;
          if (step_q == 3'(NumSteps - 1)) state_d = StDone;
          else                            step_d  = step_q + 3'd1;
        end else if (tick) begin
          sec_d = sec_q + SecW'(1);
        end
      end
      StDone: begin
        if (phase_last) begin
          state_d  = StIdle;
          change_d = '0;
        end else if (tick) begin
          sec_d = sec_q + SecW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs from registered state and step.
  always_comb begin
    valve_on         = (state_q == StDispense) && (cur_dur != 3'd0);
    bus.credit_clear = (state_q == StCheck) && accept;
    bus.change       = change_q;
    bus.reject       = (state_q == StReject);
    bus.busy         = (state_q != StIdle);
    bus.water        = valve_on && (step_q == 3'(IngWater));
    bus.coffee       = valve_on && (step_q == 3'(IngCoffee));
    bus.sugar        = valve_on && (step_q == 3'(IngSugar));
    bus.milk         = valve_on && (step_q == 3'(IngMilk));
    bus.chocolate    = valve_on && (step_q == 3'(IngChocolate));
    bus.finished     = (state_q == StDone);
    bus.state        = state_q;
  end

endmodule
